// File: rtl/contador_pops_if.sv
// Egress-FIFO pop-monitor and count read-back bundle for contador_pops.
// The master drives pop/empty/idle/req/idx; the slave (the counter block) returns data_out/valid.
interface contador_pops_if #(
    parameter int CNT_WIDTH = 5
);
    logic [3:0]           pop;
    logic [3:0]           empty;
    logic                 idle;
    logic                 req;
    logic [2:0]           idx;
    logic [CNT_WIDTH+1:0] data_out;
    logic                 valid;

    modport master (
        output pop, empty, idle, req, idx,
        input  data_out, valid
    );

    modport slave (
        input  pop, empty, idle, req, idx,
        output data_out, valid
    );
endinterface

// File: rtl/contador_pops.sv
// Per-lane pop counters for egress FIFOs 4..7, read back over req/idx only while the main FSM is idle.
// Optional macro CONTADOR_SAT_EN: saturating counters with sticky per-lane flags reported in data_out MSB.
module contador_pops #(
    parameter int CNT_WIDTH = 5,
    parameter int NUM_FIFOS = 4
) (
    input logic            clk,
    input logic            reset,
    contador_pops_if.slave bus
);
    localparam int OUT_W = CNT_WIDTH + 2;
    localparam logic [0:0] ST_COUNT = 1'b0;
    localparam logic [0:0] ST_READ  = 1'b1;

    logic [0:0]           state;
    logic [CNT_WIDTH-1:0] cnt [NUM_FIFOS];
    logic [NUM_FIFOS-1:0] hit;
    logic [OUT_W-1:0]     total;
    logic [OUT_W-1:0]     sel;
    logic [OUT_W-1:0]     data_q;
    logic [NUM_FIFOS-1:0] sat_flag;

    // Counter advance; wrap or saturate depending on build
    function automatic logic [CNT_WIDTH-1:0] next_count(input logic [CNT_WIDTH-1:0] c,
                                                         input logic inc);
        logic [CNT_WIDTH-1:0] n;
        n = c;
        if (inc) begin
`ifdef CONTADOR_SAT_EN
            if (c != {CNT_WIDTH{1'b1}}) n = c + 1'b1;
`else
            n = c + 1'b1;
`endif
        end
        return n;
    endfunction

    assign hit = bus.pop & ~bus.empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FIFOS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) cnt[i] <= next_count(cnt[i], hit[i]);
        end
    end

`ifdef CONTADOR_SAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_flag <= '0;
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++)
                if (hit[i] && cnt[i] == {CNT_WIDTH{1'b1}}) sat_flag[i] <= 1'b1;
        end
    end
`else
    assign sat_flag = '0;
`endif

    always_comb begin
        total = '0;
        for (int i = 0; i < NUM_FIFOS; i++) total = total + OUT_W'(cnt[i]);
    end

    // Read mux sees registered counters, so a read colliding with a pop returns the old value
    always_comb begin
        sel = '0;
        case (bus.idx)
            3'd0, 3'd1, 3'd2, 3'd3: begin
                sel = OUT_W'(cnt[bus.idx[1:0]]);
                sel[OUT_W-1] = sat_flag[bus.idx[1:0]];
            end
            3'd4: begin
                sel = total;
                if (|sat_flag) sel[OUT_W-1] = 1'b1;
            end
            default: sel = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_COUNT;
            data_q <= '0;
        end else if (bus.req && bus.idle) begin
            state  <= ST_READ;
            data_q <= sel;
        end else begin
            state  <= ST_COUNT;
        end
    end

    assign bus.valid    = (state == ST_READ);
    assign bus.data_out = data_q;
endmodule

// File: tb/tb_contador_pops.sv
// Directed bench for contador_pops: reset, uneven traffic, underflow, gating, wrap/saturation, reset mid-read.
module tb_contador_pops;
    localparam int CNT_WIDTH = 5;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    contador_pops_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    contador_pops #(.CNT_WIDTH(CNT_WIDTH), .NUM_FIFOS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic read_idx(input logic [2:0] i, input int exp, input string tag);
        bus.req  = 1'b1;
        bus.idle = 1'b1;
        bus.idx  = i;
        tick();
        check({tag, "_valid"}, 32'(bus.valid), 32'd1);
        check(tag, 32'(bus.data_out), 32'(exp));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        bus.pop  = 4'b1111;
        bus.empty = 4'b0000;
        bus.idle = 1'b0;
        bus.req  = 1'b0;
        bus.idx  = 3'd0;

        // Reset held with pops active
        tick();
        tick();
        check("rst_data", 32'(bus.data_out), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        bus.pop = 4'b0000;
        reset = 1'b0;
        read_idx(3'd4, 0, "rst_total");
        bus.req = 1'b0;
        tick();

        // Uneven traffic: 3,5,0,7
        for (int k = 0; k < 7; k++) begin
            bus.pop = {(k < 7), 1'b0, (k < 5), (k < 3)};
            tick();
        end
        bus.pop = 4'b0000;
        read_idx(3'd0, 3, "uneven_f4");
        read_idx(3'd1, 5, "uneven_f5");
        read_idx(3'd2, 0, "uneven_f6");
        read_idx(3'd3, 7, "uneven_f7");
        read_idx(3'd4, 15, "uneven_total");
        read_idx(3'd5, 0, "reserved_idx5");
        bus.req = 1'b0;
        tick();
        check("drop_req_valid", 32'(bus.valid), 32'd0);
        check("drop_req_hold", 32'(bus.data_out), 32'd0);

        // Underflow attempts on lanes 5 and 7
        pulse_reset();
        bus.pop = 4'b1111;
        bus.empty = 4'b1010;
        repeat (4) tick();
        bus.pop = 4'b0000;
        bus.empty = 4'b0000;
        read_idx(3'd0, 4, "undf_f4");
        read_idx(3'd1, 0, "undf_f5");
        read_idx(3'd2, 4, "undf_f6");
        read_idx(3'd3, 0, "undf_f7");
        read_idx(3'd4, 8, "undf_total");

        // Read colliding with a counted pop returns the pre-increment value
        bus.pop = 4'b0001;
        read_idx(3'd0, 4, "collide_pre");
        bus.pop = 4'b0000;
        read_idx(3'd0, 5, "collide_post");
        bus.req = 1'b0;
        tick();

        // Gating by idle
        bus.req  = 1'b1;
        bus.idle = 1'b0;
        bus.idx  = 3'd4;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("gate_valid", 32'(bus.valid), 32'd0);
        end
        bus.idle = 1'b1;
        tick();
        check("gate_open_valid", 32'(bus.valid), 32'd1);
        check("gate_open_data", 32'(bus.data_out), 32'd9);
        bus.req = 1'b0;
        tick();

        // 33 pops on FIFO4: wrap to 1, or saturate at 31 with flag
        pulse_reset();
        bus.pop = 4'b0001;
        repeat (33) tick();
        bus.pop = 4'b0000;
`ifdef CONTADOR_SAT_EN
        read_idx(3'd0, 95, "wrap_f4");
        read_idx(3'd4, 95, "wrap_total");
`else
        read_idx(3'd0, 1, "wrap_f4");
        read_idx(3'd4, 1, "wrap_total");
`endif
        read_idx(3'd1, 0, "wrap_f5");

        // Asynchronous reset in the middle of a read
        check("midrd_valid_pre", 32'(bus.valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrd_valid", 32'(bus.valid), 32'd0);
        check("midrd_data", 32'(bus.data_out), 32'd0);
        tick();
        reset = 1'b0;
        read_idx(3'd0, 0, "post_rst_f4");
        read_idx(3'd4, 0, "post_rst_total");
        bus.req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
